esfa_cmd_sequencer: RTL and testbench
=====================================

# esfa_cmd_sequencer

Command front-end directly upstream of the ESFA associative array. It accepts write, metadata-write and lookup requests over a valid/ready handshake and drives the array's write and select inputs one operation at a time. It samples the array's combinational lookup result after a fixed settle window and returns it on a held valid/ready response channel. It also gates all traffic until the array has left its power-up state.

## Interface
- SETTLE_CYCLES, 1, cycles `esfa_selector` is held before the lookup result is sampled (1..15)
- STAT_W, 16, width of the statistics counters (used only with `ESFA_SEQ_STATS_EN`)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=WRITE_VALUE, 1=WRITE_META, 2=LOOKUP, 3=reserved
- req_index  in  8  cell index for writes
- req_value  in  8  value for WRITE_VALUE
- req_metadata  in  8  metadata for WRITE_META
- req_selector  in  8  selector for any op
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_hit  out  1  sampled `esfa_result_bool`
- resp_value  out  8  sampled `esfa_result_value`
- resp_err  out  1  reserved opcode was received
- esfa_will_write  out  1  to array `in_willWrite`
- esfa_new_index, esfa_new_value, esfa_metadata, esfa_selector  out  8 each  to array
- esfa_is_metadata  out  1  to array `isMetadata`
- esfa_result_bool  in  1  from array `resultBool`
- esfa_result_value  in  8  from array `resultValue`
- stat_writes, stat_lookups, stat_hits  out  STAT_W each  present only with `ESFA_SEQ_STATS_EN`

## Operation
- All outputs are registered. On reset, every output is 0 and the state is INIT.
- **INIT:** `req_ready`=0, `esfa_selector`=0. Moves to IDLE on the first edge where `esfa_result_bool`==0 and `esfa_result_value`==0. This is the same edge at which the array releases its internal reset.
- **IDLE:** `req_ready`=1. When a request is accepted (`req_valid`&&`req_ready`), all request fields are registered onto the `esfa_*` outputs and `req_ready` drops.
  - Op 0: go to WRITE with `esfa_is_metadata`=0.
  - Op 1: go to WRITE with `esfa_is_metadata`=1.
  - Op 2: go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
  - Op 3: go directly to RESP with `resp_err`=1, `resp_hit`=0, `resp_value`=0. No array activity.
- **WRITE:** `esfa_will_write`=1 for exactly one cycle, then back to IDLE. Writes produce no response.
- **SETTLE:** decrement the counter each cycle. When the counter is 0, capture `esfa_result_bool` into `resp_hit` and `esfa_result_value` into `resp_value`, clear `resp_err`, and go to RESP.
- **RESP:** `resp_valid`=1. `resp_*` and `esfa_selector` are held stable until `resp_valid`&&`resp_ready`, then go to IDLE.
- `esfa_selector`, `esfa_new_index`, `esfa_new_value` and `esfa_metadata` keep their last values in IDLE; only `esfa_will_write` returns to 0.
- Only one request is in flight at a time; there is no queuing.

## Timing
- Request accepted at edge T.
- Write: `esfa_will_write` is high during cycle T..T+1, the array captures at edge T+1, and `req_ready` is high again from T+1.
- Lookup: `esfa_selector` is valid from T, the result is sampled at edge T+SETTLE_CYCLES, and `resp_valid` is high from that edge.
- Best-case throughput:
  - back-to-back writes: one every 2 cycles;
  - lookups: one every SETTLE_CYCLES+2 cycles with `resp_ready` tied high.
- If `resp_ready` is already high when `resp_valid` rises, the response completes in one cycle and `req_ready` rises on the following edge.
- `req_valid` held high in INIT is not accepted. The request stays pending and is taken on the first IDLE cycle.
- Reset asserted mid-operation: an in-flight write is aborted and `esfa_will_write` drops immediately; a pending response is discarded; the state returns to INIT.

## Configuration
- `ESFA_SEQ_STATS_EN` defined:
  - `stat_writes` increments on each WRITE cycle.
  - `stat_lookups` increments on each lookup sample.
  - `stat_hits` increments on each lookup sample with `resp_hit`=1.
  - All three saturate at 2^STAT_W-1 and clear on reset.
- `ESFA_SEQ_STATS_EN` undefined: the stat ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `esfa_pkg` holds:
  - opcode constants `ESFA_OP_WRITE_VALUE`, `ESFA_OP_WRITE_META`, `ESFA_OP_LOOKUP`, `ESFA_OP_RSVD`;
  - the state encoding (INIT, IDLE, WRITE, SETTLE, RESP);
  - the 8-bit data width constant `ESFA_DW`.
- One sub-module: `esfa_sat_counter` (parameterised width, enable, saturate), instantiated three times under `ESFA_SEQ_STATS_EN`.

## Test plan
- Reset release with `esfa_result_bool`=0 and `esfa_result_value`=0 → `req_ready` is 1 one cycle later; all outputs are 0 during reset.
- WRITE_VALUE, index 3, value 0x5A → exactly one cycle with `esfa_will_write`=1, `esfa_new_index`=3, `esfa_new_value`=0x5A, `esfa_is_metadata`=0; no `resp_valid`.
- LOOKUP, selector 0x5A, with the array model returning bool=1 and value 0x5A → `resp_valid` at T+SETTLE_CYCLES, `resp_hit`=1, `resp_value`=0x5A.
- LOOKUP with `resp_ready` held 0 for 5 cycles → response and `esfa_selector` remain stable for all 5 cycles; `req_ready` stays 0 until the handshake.
- Opcode 3 → `resp_err`=1, `resp_value`=0, `esfa_will_write` never asserted.
- Reset asserted during WRITE, then with stats enabled: 2 writes plus 1 lookup hit → after reset, `stat_writes`=2, `stat_lookups`=1, `stat_hits`=1; with STAT_W=2, 5 writes leave `stat_writes` saturated at 3.

Source files
------------

// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA command sequencer: opcodes, FSM states, data width.
package esfa_pkg;

   localparam int ESFA_DW  = 8;
   localparam int SETTLE_W = 4;

   localparam logic [1:0] ESFA_OP_WRITE_VALUE = 2'd0;
   localparam logic [1:0] ESFA_OP_WRITE_META  = 2'd1;
   localparam logic [1:0] ESFA_OP_LOOKUP      = 2'd2;
   localparam logic [1:0] ESFA_OP_RSVD        = 2'd3;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_WRITE  = 3'd2,
      S_SETTLE = 3'd3,
      S_RESP   = 3'd4
   } esfa_state_t;

endpackage

// File: rtl/esfa_cmd_sequencer_if.sv
// Request/response handshake plus array-side bus of the ESFA command sequencer.
interface esfa_cmd_sequencer_if;
   import esfa_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [1:0]         req_op;
   logic [ESFA_DW-1:0] req_index;
   logic [ESFA_DW-1:0] req_value;
   logic [ESFA_DW-1:0] req_metadata;
   logic [ESFA_DW-1:0] req_selector;

   logic               resp_valid;
   logic               resp_ready;
   logic               resp_hit;
   logic [ESFA_DW-1:0] resp_value;
   logic               resp_err;

   logic               esfa_will_write;
   logic [ESFA_DW-1:0] esfa_new_index;
   logic [ESFA_DW-1:0] esfa_new_value;
   logic [ESFA_DW-1:0] esfa_metadata;
   logic [ESFA_DW-1:0] esfa_selector;
   logic               esfa_is_metadata;
   logic               esfa_result_bool;
   logic [ESFA_DW-1:0] esfa_result_value;

   // slave: the sequencer; master: the requester that also models the array
   modport slave (
      input  req_valid, req_op, req_index, req_value, req_metadata, req_selector,
      input  resp_ready, esfa_result_bool, esfa_result_value,
      output req_ready, resp_valid, resp_hit, resp_value, resp_err,
      output esfa_will_write, esfa_new_index, esfa_new_value, esfa_metadata,
      output esfa_selector, esfa_is_metadata
   );

   modport master (
      output req_valid, req_op, req_index, req_value, req_metadata, req_selector,
      output resp_ready, esfa_result_bool, esfa_result_value,
      input  req_ready, resp_valid, resp_hit, resp_value, resp_err,
      input  esfa_will_write, esfa_new_index, esfa_new_value, esfa_metadata,
      input  esfa_selector, esfa_is_metadata
   );

endinterface

// File: rtl/esfa_cmd_sequencer_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module esfa_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/esfa_cmd_sequencer.sv
// One-op-at-a-time front-end for the ESFA array; all outputs registered.
// Optional statistics counters are built when ESFA_SEQ_STATS_EN is defined.
module esfa_cmd_sequencer
   import esfa_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
`ifdef ESFA_SEQ_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   esfa_cmd_sequencer_if.slave  bus
`ifdef ESFA_SEQ_STATS_EN
   , output logic [STAT_W-1:0]  o_stat_writes,
   output logic [STAT_W-1:0]    o_stat_lookups,
   output logic [STAT_W-1:0]    o_stat_hits
`endif
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   esfa_state_t         r_state, w_state_next;
   logic [SETTLE_W-1:0] r_cnt, w_cnt_next;
   logic                r_req_ready, w_req_ready_next;
   logic                r_resp_valid, w_resp_valid_next;
   logic                r_resp_hit, w_resp_hit_next;
   logic [ESFA_DW-1:0]  r_resp_value, w_resp_value_next;
   logic                r_resp_err, w_resp_err_next;
   logic                r_will_write, w_will_write_next;
   logic [ESFA_DW-1:0]  r_new_index, w_new_index_next;
   logic [ESFA_DW-1:0]  r_new_value, w_new_value_next;
   logic [ESFA_DW-1:0]  r_metadata, w_metadata_next;
   logic [ESFA_DW-1:0]  r_selector, w_selector_next;
   logic                r_is_metadata, w_is_metadata_next;
   logic                w_sample;

   assign w_sample = (r_state == S_SETTLE) && (r_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_INIT;
         r_cnt         <= '0;
         r_req_ready   <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_hit    <= 1'b0;
         r_resp_value  <= '0;
         r_resp_err    <= 1'b0;
         r_will_write  <= 1'b0;
         r_new_index   <= '0;
         r_new_value   <= '0;
         r_metadata    <= '0;
         r_selector    <= '0;
         r_is_metadata <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_req_ready   <= w_req_ready_next;
         r_resp_valid  <= w_resp_valid_next;
         r_resp_hit    <= w_resp_hit_next;
         r_resp_value  <= w_resp_value_next;
         r_resp_err    <= w_resp_err_next;
         r_will_write  <= w_will_write_next;
         r_new_index   <= w_new_index_next;
         r_new_value   <= w_new_value_next;
         r_metadata    <= w_metadata_next;
         r_selector    <= w_selector_next;
         r_is_metadata <= w_is_metadata_next;
      end
   end

   // Next values are computed for the registers so every output comes straight off a flop.
   always_comb begin
      w_state_next       = r_state;
      w_cnt_next         = r_cnt;
      w_req_ready_next   = r_req_ready;
      w_resp_valid_next  = r_resp_valid;
      w_resp_hit_next    = r_resp_hit;
      w_resp_value_next  = r_resp_value;
      w_resp_err_next    = r_resp_err;
      w_will_write_next  = 1'b0;
      w_new_index_next   = r_new_index;
      w_new_value_next   = r_new_value;
      w_metadata_next    = r_metadata;
      w_selector_next    = r_selector;
      w_is_metadata_next = r_is_metadata;

      case (r_state)
         S_INIT: begin
            // the array signals the end of its power-up by presenting an all-zero result
            if (!bus.esfa_result_bool && (bus.esfa_result_value == '0)) begin
               w_state_next     = S_IDLE;
               w_req_ready_next = 1'b1;
            end
         end
         S_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
               w_req_ready_next   = 1'b0;
               w_new_index_next   = bus.req_index;
               w_new_value_next   = bus.req_value;
               w_metadata_next    = bus.req_metadata;
               w_selector_next    = bus.req_selector;
               w_is_metadata_next = (bus.req_op == ESFA_OP_WRITE_META);
               case (bus.req_op)
                  ESFA_OP_WRITE_VALUE, ESFA_OP_WRITE_META: begin
                     w_state_next      = S_WRITE;
                     w_will_write_next = 1'b1;
                  end
                  ESFA_OP_LOOKUP: begin
                     w_state_next = S_SETTLE;
                     w_cnt_next   = SETTLE_LOAD;
                  end
                  ESFA_OP_RSVD: begin
                     w_state_next      = S_RESP;
                     w_resp_valid_next = 1'b1;
                     w_resp_err_next   = 1'b1;
                     w_resp_hit_next   = 1'b0;
                     w_resp_value_next = '0;
                  end
               endcase
            end
         end
         S_WRITE: begin
            w_state_next     = S_IDLE;
            w_req_ready_next = 1'b1;
         end
         S_SETTLE: begin
            if (w_sample) begin
               w_state_next      = S_RESP;
               w_resp_valid_next = 1'b1;
               w_resp_hit_next   = bus.esfa_result_bool;
               w_resp_value_next = bus.esfa_result_value;
               w_resp_err_next   = 1'b0;
            end else begin
               w_cnt_next = r_cnt - SETTLE_W'(1);
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               w_state_next      = S_IDLE;
               w_resp_valid_next = 1'b0;
               w_req_ready_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = S_INIT;
         end
      endcase
   end

   assign bus.req_ready        = r_req_ready;
   assign bus.resp_valid       = r_resp_valid;
   assign bus.resp_hit         = r_resp_hit;
   assign bus.resp_value       = r_resp_value;
   assign bus.resp_err         = r_resp_err;
   assign bus.esfa_will_write  = r_will_write;
   assign bus.esfa_new_index   = r_new_index;
   assign bus.esfa_new_value   = r_new_value;
   assign bus.esfa_metadata    = r_metadata;
   assign bus.esfa_selector    = r_selector;
   assign bus.esfa_is_metadata = r_is_metadata;

`ifdef ESFA_SEQ_STATS_EN
   logic [2:0]        w_stat_en;
   logic [STAT_W-1:0] w_stat_cnt [3];

   assign w_stat_en[0] = (r_state == S_WRITE);
   assign w_stat_en[1] = w_sample;
   assign w_stat_en[2] = w_sample && bus.esfa_result_bool;

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      esfa_sat_counter #(.W(STAT_W)) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .i_en    (w_stat_en[gi]),
         .o_count (w_stat_cnt[gi])
      );
   end

   assign o_stat_writes  = w_stat_cnt[0];
   assign o_stat_lookups = w_stat_cnt[1];
   assign o_stat_hits    = w_stat_cnt[2];
`endif

endmodule

// File: tb/tb_esfa_cmd_sequencer.sv
// Directed bench for esfa_cmd_sequencer: a timestamp-based reference model checked every
// cycle, a small associative-array stand-in, and literal expectations for key scenarios.
module tb_esfa_cmd_sequencer;
   import esfa_pkg::*;

   localparam int S        = 3;
   localparam int STAT_MAX = 65535;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   esfa_cmd_sequencer_if bus ();

`ifdef ESFA_SEQ_STATS_EN
   logic [15:0] stat_w, stat_l, stat_h;
`endif

   esfa_cmd_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
`ifdef ESFA_SEQ_STATS_EN
      , .o_stat_writes  (stat_w),
      .o_stat_lookups   (stat_l),
      .o_stat_hits      (stat_h)
`endif
   );

   logic       sat_en = 1'b0;
   logic [1:0] sat_cnt;
   esfa_sat_counter #(.W(2)) u_sat (
      .clk     (clk),
      .reset   (rst),
      .i_en    (sat_en),
      .o_count (sat_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Array stand-in: value cells matched against the selector; busy during power-up.
   logic [7:0] cell_val [256];
   logic       cell_ok  [256];
   logic       hold_busy = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) cell_ok[i] <= 1'b0;
      end else if (bus.esfa_will_write && !bus.esfa_is_metadata) begin
         cell_ok[bus.esfa_new_index]  <= 1'b1;
         cell_val[bus.esfa_new_index] <= bus.esfa_new_value;
      end
   end

   always_comb begin
      bus.esfa_result_bool  = hold_busy;
      bus.esfa_result_value = hold_busy ? 8'hFF : 8'h00;
      if (!hold_busy) begin
         for (int i = 0; i < 256; i++) begin
            if (cell_ok[i] && (cell_val[i] == bus.esfa_selector)) begin
               bus.esfa_result_bool  = 1'b1;
               bus.esfa_result_value = cell_val[i];
            end
         end
      end
   end

   // Reference model: expected outputs after each edge, built from edge timestamps.
   initial begin : model_cmp
      int   e, nxt, sample_at, m_sw, m_sl, m_sh;
      bit   up, in_resp;
      logic m_ready, m_rv, m_hit, m_err, m_ww, m_ismeta;
      logic [7:0] m_val, m_idx, m_nv, m_md, m_sel;
      e = 0; sample_at = -1; up = 0; in_resp = 0;
      m_sw = 0; m_sl = 0; m_sh = 0;
      {m_ready, m_rv, m_hit, m_err, m_ww, m_ismeta} = '0;
      {m_val, m_idx, m_nv, m_md, m_sel} = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sample_at = -1; up = 0; in_resp = 0;
            m_sw = 0; m_sl = 0; m_sh = 0;
            {m_ready, m_rv, m_hit, m_err, m_ww, m_ismeta} = '0;
            {m_val, m_idx, m_nv, m_md, m_sel} = '0;
         end
         check("req_ready",   bus.req_ready,        m_ready);
         check("resp_valid",  bus.resp_valid,       m_rv);
         check("resp_hit",    bus.resp_hit,         m_hit);
         check("resp_value",  bus.resp_value,       m_val);
         check("resp_err",    bus.resp_err,         m_err);
         check("will_write",  bus.esfa_will_write,  m_ww);
         check("new_index",   bus.esfa_new_index,   m_idx);
         check("new_value",   bus.esfa_new_value,   m_nv);
         check("metadata",    bus.esfa_metadata,    m_md);
         check("selector",    bus.esfa_selector,    m_sel);
         check("is_metadata", bus.esfa_is_metadata, m_ismeta);
`ifdef ESFA_SEQ_STATS_EN
         check("stat_writes",  stat_w, m_sw);
         check("stat_lookups", stat_l, m_sl);
         check("stat_hits",    stat_h, m_sh);
`endif
         nxt = e + 1;
         if (!rst) begin
            if (!up) begin
               if (!bus.esfa_result_bool && bus.esfa_result_value == 8'h00) begin
                  up = 1; m_ready = 1;
               end
            end else if (in_resp) begin
               if (bus.resp_ready) begin
                  in_resp = 0; m_rv = 0; m_ready = 1;
               end
            end else if (sample_at == nxt) begin
               m_hit = bus.esfa_result_bool; m_val = bus.esfa_result_value;
               m_err = 0; m_rv = 1; in_resp = 1; sample_at = -1;
               if (m_sl < STAT_MAX) m_sl++;
               if (m_hit && m_sh < STAT_MAX) m_sh++;
            end else if (m_ww) begin
               m_ww = 0; m_ready = 1;
               if (m_sw < STAT_MAX) m_sw++;
            end else if (m_ready && bus.req_valid) begin
               m_ready = 0;
               m_idx = bus.req_index; m_nv = bus.req_value;
               m_md = bus.req_metadata; m_sel = bus.req_selector;
               m_ismeta = (bus.req_op == 2'd1);
               if (bus.req_op == 2'd0 || bus.req_op == 2'd1) m_ww = 1;
               else if (bus.req_op == 2'd2) sample_at = nxt + S;
               else begin
                  m_rv = 1; m_err = 1; m_hit = 0; m_val = 0; in_resp = 1;
               end
            end
         end
         e = nxt;
      end
   end

   task automatic start_req(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val,
                            input logic [7:0] md, input logic [7:0] sel);
      bus.req_op = op; bus.req_index = idx; bus.req_value = val;
      bus.req_metadata = md; bus.req_selector = sel; bus.req_valid = 1'b1;
   endtask

   // Returns at 1 ns after the accepting edge with that edge's cycle number.
   task automatic wait_accept(output int t);
      logic seen;
      t = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); seen = bus.req_ready;
         @(posedge clk); #1;
         if (seen) begin
            t = tb_cyc; bus.req_valid = 1'b0;
            $display("accepted op=%0d sel=0x%0h at cycle %0d", bus.req_op, bus.req_selector, t);
            return;
         end
      end
      bus.req_valid = 1'b0;
      check("accept_timeout", bus.req_ready, 1'b1);
   endtask

   task automatic wait_resp(output int t);
      t = -1;
      for (int k = 0; k < 40; k++) begin
         if (bus.resp_valid) begin
            t = tb_cyc;
            $display("response hit=%0d value=0x%0h err=%0d at cycle %0d",
                     bus.resp_hit, bus.resp_value, bus.resp_err, t);
            return;
         end
         @(posedge clk); #1;
      end
      check("resp_timeout", bus.resp_valid, 1'b1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100 us");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t1, t2, t3, tl1, tl2, tr;
      logic [7:0] hold_sel;
      bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_index = 8'h00; bus.req_value = 8'h00;
      bus.req_metadata = 8'h00; bus.req_selector = 8'h00; bus.resp_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", bus.req_ready, 1'b0);
      check("rst_selector", bus.esfa_selector, 8'h00);
      check("rst_resp_valid", bus.resp_valid, 1'b0);

      // request pending while the array is still powering up
      start_req(ESFA_OP_WRITE_VALUE, 8'd3, 8'h5A, 8'h00, 8'h00);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("init_req_ready", bus.req_ready, 1'b0);
      end
      hold_busy = 1'b0;
      wait_accept(t1);
      check("wr_will_write", bus.esfa_will_write, 1'b1);
      check("wr_index", bus.esfa_new_index, 8'd3);
      check("wr_value", bus.esfa_new_value, 8'h5A);
      check("wr_is_meta", bus.esfa_is_metadata, 1'b0);
      check("wr_resp_valid", bus.resp_valid, 1'b0);
      @(posedge clk); #1;
      check("wr_pulse_end", bus.esfa_will_write, 1'b0);
      check("wr_ready_back", bus.req_ready, 1'b1);

      start_req(ESFA_OP_WRITE_VALUE, 8'd4, 8'h11, 8'h00, 8'h00);
      wait_accept(t2);
      check("b2b_write_gap1", t2 - t1, 2);
      start_req(ESFA_OP_WRITE_META, 8'd9, 8'h00, 8'hC3, 8'h00);
      wait_accept(t3);
      check("b2b_write_gap2", t3 - t2, 2);
      check("meta_is_meta", bus.esfa_is_metadata, 1'b1);
      check("meta_value", bus.esfa_metadata, 8'hC3);

      // lookup hit on 0x5A, then a second lookup right behind it
      start_req(ESFA_OP_LOOKUP, 8'h00, 8'h00, 8'h00, 8'h5A);
      wait_accept(tl1);
      wait_resp(tr);
      check("lk_latency", tr - tl1, S);
      check("lk_hit", bus.resp_hit, 1'b1);
      check("lk_value", bus.resp_value, 8'h5A);
      check("lk_err", bus.resp_err, 1'b0);
      start_req(ESFA_OP_LOOKUP, 8'h00, 8'h00, 8'h00, 8'h99);
      wait_accept(tl2);
      check("lk_throughput", tl2 - tl1, S + 2);
      wait_resp(tr);
      check("miss_hit", bus.resp_hit, 1'b0);
      check("miss_value", bus.resp_value, 8'h00);
      @(posedge clk); #1;

      // consumer stalls for 5 cycles
      bus.resp_ready = 1'b0;
      start_req(ESFA_OP_LOOKUP, 8'h00, 8'h00, 8'h00, 8'h11);
      wait_accept(t1);
      wait_resp(tr);
      hold_sel = bus.esfa_selector;
      check("stall_sel_init", hold_sel, 8'h11);
      repeat (5) begin
         @(posedge clk); #1;
         check("stall_valid", bus.resp_valid, 1'b1);
         check("stall_value", bus.resp_value, 8'h11);
         check("stall_sel", bus.esfa_selector, hold_sel);
         check("stall_ready", bus.req_ready, 1'b0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_done_valid", bus.resp_valid, 1'b0);
      check("stall_done_ready", bus.req_ready, 1'b1);

      // reserved opcode
      start_req(ESFA_OP_RSVD, 8'h44, 8'h55, 8'h00, 8'h66);
      wait_accept(t1);
      check("rsvd_valid", bus.resp_valid, 1'b1);
      check("rsvd_err", bus.resp_err, 1'b1);
      check("rsvd_value", bus.resp_value, 8'h00);
      check("rsvd_hit", bus.resp_hit, 1'b0);
      check("rsvd_no_write", bus.esfa_will_write, 1'b0);
      start_req(ESFA_OP_LOOKUP, 8'h00, 8'h00, 8'h00, 8'h5A);
      wait_accept(t1);
      wait_resp(tr);
      check("err_cleared", bus.resp_err, 1'b0);
      @(posedge clk); #1;

      // reset while a write is in flight
      start_req(ESFA_OP_WRITE_VALUE, 8'd5, 8'h33, 8'h00, 8'h00);
      wait_accept(t1);
      check("abort_ww_before", bus.esfa_will_write, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("abort_ww", bus.esfa_will_write, 1'b0);
      check("abort_ready", bus.req_ready, 1'b0);
      check("abort_sel", bus.esfa_selector, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("release_ready", bus.req_ready, 1'b1);

`ifdef ESFA_SEQ_STATS_EN
      start_req(ESFA_OP_WRITE_VALUE, 8'd2, 8'h77, 8'h00, 8'h00);
      wait_accept(t1);
      start_req(ESFA_OP_WRITE_VALUE, 8'd6, 8'h78, 8'h00, 8'h00);
      wait_accept(t1);
      start_req(ESFA_OP_LOOKUP, 8'h00, 8'h00, 8'h00, 8'h77);
      wait_accept(t1);
      wait_resp(tr);
      @(posedge clk); #1;
      check("stat_writes_lit", stat_w, 16'd2);
      check("stat_lookups_lit", stat_l, 16'd1);
      check("stat_hits_lit", stat_h, 16'd1);
`endif

      // 2-bit saturating counter: 5 enables stop at 3
      check("sat_start", sat_cnt, 2'd0);
      sat_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("sat_mid", sat_cnt, 2'd2);
      repeat (3) @(posedge clk);
      #1 sat_en = 1'b0;
      check("sat_full", sat_cnt, 2'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
